// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
//   Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
//   A byte is taken over a valid/ready handshake and shifted out on spi_mosi
//   while the peripheral's reply is shifted in from spi_miso. Chip select
//   stays low between bytes until a byte marked tx_last has been sent.
//
// Parameters
//   CLK_DIV   spi_clk half-period in clk_in cycles (1..255)
//
// Ports
//   clk_in    system clock, all logic on its rising edge
//   rst       synchronous active-high reset
//   tx_valid  byte offered for transmission
//   tx_data   byte to send, MSB first
//   tx_last   release chip select after this byte
//   tx_ready  byte accepted on this cycle when tx_valid is also high
//   rx_valid  one-cycle pulse: rx_data holds a newly received byte
//   rx_data   last complete byte received on spi_miso
//   busy      transaction in progress (any state but IDLE)
//   spi_clk   SPI clock, idle low
//   spi_mosi  SPI data out, forced low while deselected
//   spi_miso  SPI data in, sampled on the spi_clk falling edge
//   spi_cs_n  SPI chip select, active low
// ---------------------------------------------------------------------------
module spi_master #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       spi_clk,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       spi_cs_n
);

   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      GAP,
      HOLD,
      DESEL
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;        // phase length counter
   logic [2:0] bit_q, bit_d;        // HIGH phases completed in this byte
   logic [7:0] tx_sh_q, tx_sh_d;    // transmit shift register, bit 7 on the wire
   logic       last_q, last_d;
   logic [7:0] rx_sh_q, rx_sh_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       sclk_q, sclk_d;
   logic       cs_n_q, cs_n_d;
   logic       mosi_q, mosi_d;

   logic       phase_done;

   assign phase_done = (cnt_q == 8'd0);

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         bit_q      <= 3'd0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         sclk_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
      end
      // Shift registers carry no control meaning; a partial byte left here
      // by a reset is fully overwritten by the next byte.
      tx_sh_q <= tx_sh_d;
      last_q  <= last_d;
      rx_sh_q <= rx_sh_d;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      tx_sh_d    = tx_sh_q;
      last_d     = last_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               tx_sh_d = tx_data;
               last_d  = tx_last;
               bit_d   = 3'd0;
               cnt_d   = DIV_M1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (phase_done) begin
               cnt_d   = DIV_M1;
               state_d = HIGH;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         HIGH: begin
            if (phase_done) begin
               // This edge drives spi_clk low: sample miso here.
               rx_sh_d = {rx_sh_q[6:0], spi_miso};
               cnt_d   = DIV_M1;
               if (bit_q == 3'd7) begin
                  // Eighth HIGH ends the byte with no trailing LOW phase.
                  rx_data_d  = {rx_sh_q[6:0], spi_miso};
                  rx_valid_d = 1'b1;
                  bit_d      = 3'd0;
                  state_d    = last_q ? HOLD : GAP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  tx_sh_d = {tx_sh_q[6:0], 1'b0};
                  state_d = LOW;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         LOW: begin
            if (phase_done) begin
               cnt_d   = DIV_M1;
               state_d = HIGH;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         GAP: begin
            // Chip select held low indefinitely; the next byte enters via LOW
            // so its first bit still gets a full half-period of setup.
            if (tx_valid) begin
               tx_sh_d = tx_data;
               last_d  = tx_last;
               bit_d   = 3'd0;
               cnt_d   = DIV_M1;
               state_d = LOW;
            end
         end
         HOLD: begin
            if (phase_done) begin
               cnt_d   = DIV_M1;
               state_d = DESEL;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         DESEL: begin
            if (phase_done) begin
               cnt_d   = 8'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            cnt_d   = 8'd0;
            state_d = IDLE;
         end
      endcase

      // Bus pins are registered from the next state so they change cleanly
      // together with the state register.
      sclk_d = (state_d == HIGH);
      cs_n_d = (state_d == IDLE) || (state_d == DESEL);
      mosi_d = 1'b0;
      if ((state_d == SETUP) || (state_d == HIGH) || (state_d == LOW)) begin
         mosi_d = tx_sh_d[7];
      end
   end

   assign tx_ready = (state_q == IDLE) || (state_q == GAP);
   assign busy     = (state_q != IDLE);
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
   assign spi_clk  = sclk_q;
   assign spi_cs_n = cs_n_q;
   assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// ---------------------------------------------------------------------------
// tb_spi_master
//   Three spi_master instances (CLK_DIV = 2, 1, 255) driven one at a time.
//   Stimulus pushes expected MOSI bytes, expected received bytes and the
//   peripheral's reply bytes into shared queues; a monitor process models
//   the mode-0 peripheral, reassembles MOSI bytes, times spi_clk phases and
//   chip-select windows, and pops/compares whenever the DUT presents data.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master;

   logic            clk = 1'b0;
   logic [2:0]      rst;
   logic [2:0]      tx_valid;
   logic [2:0]      tx_last;
   logic [2:0]      spi_miso;
   logic [2:0][7:0] tx_data;
   wire  [2:0]      tx_ready;
   wire  [2:0]      rx_valid;
   wire  [2:0]      busy;
   wire  [2:0]      spi_clk;
   wire  [2:0]      spi_mosi;
   wire  [2:0]      spi_cs_n;
   wire  [2:0][7:0] rx_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic mon_en = 1'b0;

   logic [7:0] exp_tx_q[$];
   logic [7:0] exp_rx_q[$];
   logic [7:0] resp_q[$];

   int   rises[3];
   int   rxv_n[3];
   int   cs_rises[3];
   int   exp_cs_low[3];
   int   last_rise[3];
   int   last_fall[3];
   int   cs_fall_cyc[3];
   int   bcnt[3];
   int   pcnt[3];
   logic [7:0] msh[3];
   logic [7:0] psh[3];
   logic prev_clk[3];
   logic prev_cs[3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      spi_master #(.CLK_DIV(g == 0 ? 2 : (g == 1 ? 1 : 255))) u_dut (
         .clk_in   (clk),
         .rst      (rst[g]),
         .tx_valid (tx_valid[g]),
         .tx_data  (tx_data[g]),
         .tx_last  (tx_last[g]),
         .tx_ready (tx_ready[g]),
         .rx_valid (rx_valid[g]),
         .rx_data  (rx_data[g]),
         .busy     (busy[g]),
         .spi_clk  (spi_clk[g]),
         .spi_mosi (spi_mosi[g]),
         .spi_miso (spi_miso[g]),
         .spi_cs_n (spi_cs_n[g])
      );
   end

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic int div_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 255);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got nothing within bound, want event (cycle %0d)", name, cyc);
   endtask

   // Monitor, peripheral model and scoreboard.
   initial begin
      logic [7:0] e;
      spi_miso = 3'b000;
      for (int i = 0; i < 3; i++) begin
         rises[i] = 0; rxv_n[i] = 0; cs_rises[i] = 0; exp_cs_low[i] = 0;
         last_rise[i] = 0; last_fall[i] = 0; cs_fall_cyc[i] = 0;
         bcnt[i] = 0; pcnt[i] = 0; msh[i] = 8'h00; psh[i] = 8'h00;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (mon_en) begin
               if (spi_cs_n[i] === 1'b1) check("mosi_low_when_deselected", 32'(spi_mosi[i]), 32'd0);
               if (prev_cs[i] && !spi_cs_n[i]) begin
                  cs_fall_cyc[i] = cyc;
                  bcnt[i] = 0;
                  pcnt[i] = 0;
                  psh[i] = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
                  spi_miso[i] = psh[i][7];
               end
               if (!prev_cs[i] && spi_cs_n[i]) begin
                  cs_rises[i]++;
                  bcnt[i] = 0;
                  if (exp_cs_low[i] != 0) check("cs_low_len", cyc - cs_fall_cyc[i], exp_cs_low[i]);
               end
               if (!prev_clk[i] && spi_clk[i]) begin
                  rises[i]++;
                  if (bcnt[i] != 0) check("sclk_low_len", cyc - last_fall[i], div_of(i));
                  last_rise[i] = cyc;
                  msh[i] = {msh[i][6:0], spi_mosi[i]};
                  bcnt[i]++;
                  if (bcnt[i] == 8) begin
                     bcnt[i] = 0;
                     if (exp_tx_q.size() == 0) begin
                        fail_now("mosi_byte_unexpected");
                     end else begin
                        e = exp_tx_q.pop_front();
                        check("mosi_byte", 32'(msh[i]), 32'(e));
                     end
                  end
               end
               if (prev_clk[i] && !spi_clk[i]) begin
                  check("sclk_high_len", cyc - last_rise[i], div_of(i));
                  last_fall[i] = cyc;
                  pcnt[i]++;
                  if (pcnt[i] == 8) begin
                     pcnt[i] = 0;
                     psh[i] = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
                  end else begin
                     psh[i] = {psh[i][6:0], 1'b0};
                  end
                  spi_miso[i] = psh[i][7];
               end
               if (rx_valid[i] === 1'b1) begin
                  rxv_n[i]++;
                  if (exp_rx_q.size() == 0) begin
                     fail_now("rx_valid_unexpected");
                  end else begin
                     e = exp_rx_q.pop_front();
                     check("rx_byte", 32'(rx_data[i]), 32'(e));
                  end
               end
            end
            prev_clk[i] = spi_clk[i];
            prev_cs[i]  = spi_cs_n[i];
         end
      end
   end

   // All stimulus tasks start and end at posedge + 1.
   task automatic send_byte(input int i, input logic [7:0] d, input logic last, input logic hold);
      int n;
      n = 0;
      tx_valid[i] = 1'b1;
      tx_data[i]  = d;
      tx_last[i]  = last;
      while (tx_ready[i] !== 1'b1 && n < 20000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20000) fail_now("send_accept");
      else begin
         @(posedge clk); #1;
      end
      if (!hold) tx_valid[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, output int desel);
      int n;
      n = 0;
      desel = 0;
      while (busy[i] !== 1'b0 && n < 20000) begin
         if (spi_cs_n[i] === 1'b1) desel++;
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20000) fail_now("wait_idle");
   endtask

   task automatic wait_rises(input int i, input int base, input int target);
      int n;
      n = 0;
      while (rises[i] - base < target && n < 20000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20000) fail_now("wait_sclk_rises");
   endtask

   initial begin
      int r0, v0, c0, desel;
      rst      = 3'b111;
      tx_valid = 3'b001;       // offered during reset: must be ignored
      tx_last  = 3'b000;
      tx_data  = '0;
      tx_data[0] = 8'h55;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("rst_tx_ready", 32'(tx_ready[i]), 32'd1);
         check("rst_busy",     32'(busy[i]),     32'd0);
         check("rst_cs_n",     32'(spi_cs_n[i]), 32'd1);
         check("rst_sclk",     32'(spi_clk[i]),  32'd0);
         check("rst_mosi",     32'(spi_mosi[i]), 32'd0);
         check("rst_rx_valid", 32'(rx_valid[i]), 32'd0);
         check("rst_rx_data",  32'(rx_data[i]),  32'h00);
      end
      tx_valid = 3'b000;
      mon_en = 1'b1;
      @(posedge clk); #1;
      rst = 3'b000;
      @(posedge clk); #1;

      // 0xA5 with tx_last, peripheral replies 0x3C.
      r0 = rises[0]; v0 = rxv_n[0];
      resp_q.push_back(8'h3C); exp_tx_q.push_back(8'hA5); exp_rx_q.push_back(8'h3C);
      exp_cs_low[0] = 34;
      send_byte(0, 8'hA5, 1'b1, 1'b0);
      check("a5_busy", 32'(busy[0]), 32'd1);
      wait_done(0, desel);
      check("a5_desel_len", desel, 2);
      check("a5_rises", rises[0] - r0, 8);
      check("a5_rx_pulses", rxv_n[0] - v0, 1);
      check("a5_ready_after", 32'(tx_ready[0]), 32'd1);
      exp_cs_low[0] = 0;

      // 0x01 (no last), 10-cycle gap, 0x80 (last).
      r0 = rises[0]; v0 = rxv_n[0]; c0 = cs_rises[0];
      resp_q.push_back(8'h5A); resp_q.push_back(8'hC3);
      exp_tx_q.push_back(8'h01); exp_tx_q.push_back(8'h80);
      exp_rx_q.push_back(8'h5A); exp_rx_q.push_back(8'hC3);
      send_byte(0, 8'h01, 1'b0, 1'b0);
      begin
         int n;
         n = 0;
         while (tx_ready[0] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
         end
         if (n >= 200) fail_now("gap_reached");
      end
      for (int k = 0; k < 10; k++) begin
         check("gap_cs_n", 32'(spi_cs_n[0]), 32'd0);
         check("gap_sclk", 32'(spi_clk[0]),  32'd0);
         check("gap_busy", 32'(busy[0]),     32'd1);
         @(posedge clk); #1;
      end
      send_byte(0, 8'h80, 1'b1, 1'b0);
      wait_done(0, desel);
      check("gap_cs_rises", cs_rises[0] - c0, 1);
      check("gap_rises", rises[0] - r0, 16);
      check("gap_rx_pulses", rxv_n[0] - v0, 2);

      // 0xFF offered mid-byte must be ignored.
      r0 = rises[0]; v0 = rxv_n[0];
      resp_q.push_back(8'h96); exp_tx_q.push_back(8'h69); exp_rx_q.push_back(8'h96);
      send_byte(0, 8'h69, 1'b1, 1'b0);
      wait_rises(0, r0, 2);
      tx_valid[0] = 1'b1; tx_data[0] = 8'hFF; tx_last[0] = 1'b0;
      @(posedge clk); #1;
      tx_valid[0] = 1'b0;
      wait_rises(0, r0, 5);
      tx_valid[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tx_valid[0] = 1'b0;
      wait_done(0, desel);
      check("ign_rises", rises[0] - r0, 8);
      check("ign_rx_pulses", rxv_n[0] - v0, 1);

      // Reset one cycle after the third rising spi_clk.
      r0 = rises[0]; v0 = rxv_n[0];
      resp_q.push_back(8'hE7);
      send_byte(0, 8'h5C, 1'b1, 1'b0);
      wait_rises(0, r0, 3);
      rst[0] = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_cs_n",     32'(spi_cs_n[0]), 32'd1);
      check("mid_rst_sclk",     32'(spi_clk[0]),  32'd0);
      check("mid_rst_rx_valid", 32'(rx_valid[0]), 32'd0);
      rst[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_ready", 32'(tx_ready[0]), 32'd1);
      check("post_rst_busy",  32'(busy[0]),     32'd0);
      check("post_rst_rises", rises[0] - r0, 3);
      check("post_rst_rx_pulses", rxv_n[0] - v0, 0);

      // CLK_DIV=1, valid held across four bytes.
      r0 = rises[1]; v0 = rxv_n[1]; c0 = cs_rises[1];
      resp_q.push_back(8'hEE); resp_q.push_back(8'hDD);
      resp_q.push_back(8'hCC); resp_q.push_back(8'hBB);
      exp_tx_q.push_back(8'h11); exp_tx_q.push_back(8'h22);
      exp_tx_q.push_back(8'h33); exp_tx_q.push_back(8'h44);
      exp_rx_q.push_back(8'hEE); exp_rx_q.push_back(8'hDD);
      exp_rx_q.push_back(8'hCC); exp_rx_q.push_back(8'hBB);
      exp_cs_low[1] = 68;
      send_byte(1, 8'h11, 1'b0, 1'b1);
      send_byte(1, 8'h22, 1'b0, 1'b1);
      send_byte(1, 8'h33, 1'b0, 1'b1);
      send_byte(1, 8'h44, 1'b1, 1'b0);
      wait_done(1, desel);
      check("burst_desel_len", desel, 1);
      check("burst_rises", rises[1] - r0, 32);
      check("burst_rx_pulses", rxv_n[1] - v0, 4);
      check("burst_cs_rises", cs_rises[1] - c0, 1);

      // CLK_DIV=255, one byte.
      r0 = rises[2]; v0 = rxv_n[2];
      resp_q.push_back(8'h81); exp_tx_q.push_back(8'h7E); exp_rx_q.push_back(8'h81);
      exp_cs_low[2] = 17 * 255;
      send_byte(2, 8'h7E, 1'b1, 1'b0);
      wait_done(2, desel);
      check("slow_desel_len", desel, 255);
      check("slow_rises", rises[2] - r0, 8);
      check("slow_rx_pulses", rxv_n[2] - v0, 1);

      repeat (3) @(posedge clk);
      #1;
      check("exp_tx_drained", exp_tx_q.size(), 0);
      check("exp_rx_drained", exp_rx_q.size(), 0);
      check("resp_drained",   resp_q.size(),   0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have one parameter: CLK_DIV, default 2, meaning spi_clk half-period in clk_in cycles (legal 1..255).
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port tx_valid, input, 1 bit: a byte is offered for transmission.
REQ-005 The block SHALL have port tx_data, input, 8 bits: the byte to send, MSB first.
REQ-006 The block SHALL have port tx_last, input, 1 bit: deassert chip select after this byte.
REQ-007 The block SHALL have port tx_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-008 The block SHALL have port rx_valid, output, 1 bit: a one-cycle pulse indicating rx_data holds a completed received byte.
REQ-009 The block SHALL have port rx_data, output, 8 bits: the last byte received on spi_miso.
REQ-010 The block SHALL have port busy, output, 1 bit: a transaction is in progress.
REQ-011 The block SHALL have ports spi_clk (output, 1 bit), spi_mosi (output, 1 bit), spi_miso (input, 1 bit) and spi_cs_n (output, 1 bit, active-low): the SPI bus, mode 0, where the peripheral shifts on the falling edge and samples on the rising edge.

Function
REQ-012 The FSM SHALL have states IDLE, SETUP, HIGH, LOW, GAP, HOLD and DESEL.
REQ-013 A byte SHALL be accepted on a clk_in edge where tx_valid && tx_ready; tx_data and tx_last SHALL be latched only then, and tx_valid SHALL be ignored while tx_ready=0.
REQ-014 tx_ready SHALL be 1 only in IDLE and GAP.
REQ-015 On acceptance in IDLE, the FSM SHALL go to SETUP: spi_cs_n=0, spi_clk=0, spi_mosi=bit7, held CLK_DIV cycles, then HIGH.
REQ-016 In HIGH, spi_clk SHALL be 1 for CLK_DIV cycles.
REQ-017 spi_miso SHALL be shifted into the receive register on the clk_in edge that ends HIGH (the edge driving spi_clk 1->0).
REQ-018 In LOW, spi_clk SHALL be 0 and spi_mosi SHALL present the next bit, for CLK_DIV cycles, then HIGH.
REQ-019 A 3-bit counter SHALL count HIGH phases; the 8th HIGH phase SHALL end the byte with no LOW phase after it.
REQ-020 On the edge that ends the 8th HIGH, rx_data SHALL be updated and rx_valid SHALL be 1 for exactly the following cycle.
REQ-021 On that same edge, the FSM SHALL go to HOLD if the latched tx_last=1, else to GAP.
REQ-022 In GAP, spi_cs_n SHALL stay 0 and spi_clk SHALL stay 0 for unbounded time.
REQ-023 On acceptance in GAP, spi_mosi SHALL take bit7 and the FSM SHALL go to LOW, so every bit gets CLK_DIV cycles of setup before the rising edge.
REQ-024 In HOLD, spi_cs_n=0 and spi_clk=0 for CLK_DIV cycles; the FSM SHALL then go to DESEL with spi_cs_n=1 for CLK_DIV cycles, then IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 spi_mosi SHALL be 0 whenever spi_cs_n=1.
REQ-027 The phase counter SHALL be 8 bits and reload CLK_DIV-1 at each phase entry; with CLK_DIV=1 each phase SHALL last exactly 1 cycle.
REQ-028 Byte time from the first rising spi_clk to the last falling spi_clk SHALL be exactly 15*CLK_DIV cycles.
REQ-029 The spi_clk period SHALL be 2*CLK_DIV cycles.

Reset
REQ-030 While rst=1 at a clk_in edge, the following SHALL be set: state=IDLE, spi_cs_n=1, spi_clk=0, spi_mosi=0, tx_ready=1, rx_valid=0, rx_data=0x00, busy=0, and all counters 0.
REQ-031 rst SHALL take priority over any simultaneous tx_valid.
REQ-032 Reset mid-byte SHALL discard the partial byte, SHALL NOT generate rx_valid, and spi_cs_n SHALL rise on the reset edge.

Verification
REQ-033 CLK_DIV=2, send 0xA5 with tx_last=1, peripheral model returns 0x3C -> mosi samples at rising edges 1,0,1,0,0,1,0,1; exactly 8 rising edges; rx_valid once with 0x3C; spi_cs_n low 2+30+2 cycles, then high for at least 2 cycles before tx_ready.
REQ-034 Send 0x01 (tx_last=0), wait 10 idle cycles, send 0x80 (tx_last=1) -> spi_cs_n stays low through the gap; spi_clk stays low during the gap; two rx_valid pulses.
REQ-035 Assert rst one cycle after the 3rd rising spi_clk -> next cycle spi_cs_n=1, spi_clk=0, no rx_valid; after release tx_ready=1 and busy=0.
REQ-036 CLK_DIV=1, tx_valid held high with 4 bytes 0x11,0x22,0x33,0x44, last on 0x44 -> spi_clk period 2 cycles; exactly 32 rising edges; 4 rx_valid pulses; spi_cs_n low continuously.
REQ-037 Pulse tx_valid with 0xFF during HIGH/LOW of an ongoing byte -> the byte is not accepted and not transmitted; the current byte completes unchanged.
REQ-038 CLK_DIV=255, one byte -> each spi_clk half-period is exactly 255 cycles; the counter does not wrap early.
